input_debouncer: RTL and testbench

Multi-channel input reader for the iCEstick: synchronises asynchronous switch/button/PMOD inputs to the 12 MHz system clock, debounces each channel, and reports a stable level plus one-cycle rise/fall event pulses per channel. It is the input-side counterpart of the LED output path and sits between the board pins and user logic.

---
 rtl/input_debouncer_pkg.sv | 15 +
 rtl/debounce_channel.sv | 68 ++++++
 rtl/input_debouncer.sv | 41 ++++
 tb/tb_input_debouncer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input_debouncer block.
package input_debouncer_pkg;

  // 10 ms at the 12 MHz board clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 120000;

  // Short window so simulations reach events in a handful of cycles.
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;

  // Counter width needed to hold 0 .. cycles-1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: two-flop synchroniser, stability counter and
// registered rise/fall pulse generator. Synchronous active-high reset.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Next-state: count cycles where the synchronised level disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Count saturates here by construction, so it never wraps.
      state_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any pending count and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel synchronise/debounce front end for board inputs.
// Optional macro INPUT_DEBOUNCER_INVERT_EN inverts pin polarity (pull-up
// buttons) ahead of the synchronisers; reset values are unaffected.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned N               = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] state,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] raw_pol;

`ifdef INPUT_DEBOUNCER_INVERT_EN
  // Pin driven low reads as an asserted level.
  assign raw_pol = ~raw;
`else
  assign raw_pol = raw;
`endif

  // Identical independent lanes, one per input pin.
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_pol[i]),
      .state(state[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// sliding-window reference model.
module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int unsigned N = 5;
  localparam int unsigned D = SIM_DEBOUNCE_CYCLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] state, rise, fall;

  int tests = 0;
  int fails = 0;

  input_debouncer #(
    .N(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw),
    .state(state),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  // Logical level -> pin level for the current build polarity.
  function automatic logic [N-1:0] pin(input logic [N-1:0] v);
`ifdef INPUT_DEBOUNCER_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with the accepted level on D consecutive edges since the last
  // accepted change. win[i] records that disagreement history as bits.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_rise = '0, m_fall = '0;
  int           win[N];
  int           edge_no = 0;

  initial begin
    for (int i = 0; i < N; i++) win[i] = 0;
    forever begin
      logic [N-1:0] r;
      logic         rs;
      @(posedge clk);
      rs = rst;
      r  = pin(raw);  // pin() is its own inverse
      edge_no++;
      m_rise = '0;
      m_fall = '0;
      if (rs) begin
        m_s1 = '0;
        m_s2 = '0;
        m_state = '0;
        for (int i = 0; i < N; i++) win[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          win[i] = ((win[i] << 1) | ((m_s2[i] != m_state[i]) ? 1 : 0)) & ((1 << D) - 1);
          if (win[i] == (1 << D) - 1) begin
            m_state[i] = ~m_state[i];
            m_rise[i]  = m_state[i];
            m_fall[i]  = ~m_state[i];
            win[i]     = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = r;
      end
      #1;
      tests++;
      if ({state, rise, fall} !== {m_state, m_rise, m_fall}) begin
        fails++;
        $display("FAIL model edge %0d: state/rise/fall got %b/%b/%b want %b/%b/%b",
                 edge_no, state, rise, fall, m_state, m_rise, m_fall);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  initial begin
    // Reset with all inputs asserted.
    rst = 1'b1;
    raw = pin(5'b11111);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("reset_state", state, 5'b00000);
      chk("reset_pulses", rise | fall, 5'b00000);
    end
    rst = 1'b0;                    // next posedge is e0
    step(5);                       // after e0+4
    chk("rst_rel_e4_state", state, 5'b00000);
    chk("rst_rel_e4_rise", rise, 5'b00000);
    step(1);                       // after e0+5
    chk("rst_rel_e5_rise", rise, 5'b11111);
    chk("rst_rel_e5_state", state, 5'b11111);
    step(1);
    chk("rst_rel_e6_rise", rise, 5'b00000);

    // Return everything low.
    raw = pin(5'b00000);
    step(6);
    chk("all_fall", fall, 5'b11111);
    step(2);

    // Clean press and release on ch0.
    raw = pin(5'b00001);
    step(5);
    chk("press_e4", rise, 5'b00000);
    step(1);
    chk("press_e5_rise", rise, 5'b00001);
    chk("press_e5_state", state, 5'b00001);
    step(1);
    chk("press_e6_rise", rise, 5'b00000);
    raw = pin(5'b00000);
    step(6);
    chk("release_e5_fall", fall, 5'b00001);
    chk("release_e5_state", state, 5'b00000);
    step(2);

    // Glitch on ch2 shorter than the window.
    raw = pin(5'b00100);
    step(3);
    raw = pin(5'b00000);
    step(10);
    chk("glitch_state", state, 5'b00000);

    // Bounce on ch1: 1,1,0 then held 1; count restarts at the second 1-run.
    raw = pin(5'b00010);
    step(2);
    raw = pin(5'b00000);
    step(1);
    raw = pin(5'b00010);           // restart edge e0'
    step(5);
    chk("bounce_e4", rise, 5'b00000);
    step(1);
    chk("bounce_e5_rise", rise, 5'b00010);
    step(4);

    // Simultaneous: ch4 high first, then ch3 rises while ch4 falls.
    raw = pin(5'b10010);
    step(8);
    chk("simul_setup", state, 5'b10010);
    raw = pin(5'b01010);
    step(6);
    chk("simul_rise", rise, 5'b01000);
    chk("simul_fall", fall, 5'b10000);
    step(2);

    // Reset mid-count discards the pending transition.
    raw = pin(5'b01011);
    step(3);
    rst = 1'b1;
    step(2);
    chk("rst_mid_state", state, 5'b00000);
    chk("rst_mid_pulses", rise | fall, 5'b00000);
    rst = 1'b0;
    raw = pin(5'b00000);
    step(8);
    chk("rst_mid_quiet", state, 5'b00000);

    // Randomized segments with occasional resets; the model checks each edge.
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 2));
        rst = 1'b0;
      end
      raw = N'($urandom);
      step($urandom_range(1, 8));
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
